// File: rtl/mac_host_sequencer_pkg.sv
// mac_host_sequencer_pkg: shared ctrl/state bit positions, FSM encoding and defaults for the host sequencer
package mac_host_sequencer_pkg;
    localparam int DWIDTH_DEF = 32;
    localparam int D_LEN_DEF  = 32;
    localparam int LEN_W      = 13;
    localparam int CTRL_W     = 16;
    localparam int CTRL_START   = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_LEN_LSB = 2;
    localparam int CTRL_ABORT   = 15;
    localparam int ST_FINISH      = 0;
    localparam int ST_ADDER_BUSY  = 1;
    localparam int ST_MULT_BUSY   = 2;
    localparam int ST_BUS_CRASH   = 3;
    localparam int ST_SPACE_ERR   = 4;
    localparam int ST_REQUIRE_ERR = 5;
    localparam int ST_EDB_BUSY    = 6;
    localparam logic [2:0] ERR_LEN     = 3'b001;
    localparam logic [2:0] ERR_MAC     = 3'b010;
    localparam logic [2:0] ERR_TIMEOUT = 3'b100;
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_START, S_WAIT, S_CAPTURE, S_RESULT, S_ABORT
    } seq_state_e;
    function automatic logic [CTRL_W-1:0] mk_ctrl(input logic abort, input logic [LEN_W-1:0] len,
                                                  input logic clr, input logic start);
        logic [CTRL_W-1:0] c;
        c = '0;
        c[CTRL_ABORT] = abort;
        c[CTRL_LEN_LSB +: LEN_W] = len;
        c[CTRL_CLEAR] = clr;
        c[CTRL_START] = start;
        return c;
    endfunction
endpackage

// File: rtl/mac_host_sequencer_if.sv
// mac_host_sequencer_if: host bus plus N_MAC command/operand signals; slave = sequencer side
interface mac_host_sequencer_if
    import mac_host_sequencer_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int D_LEN  = D_LEN_DEF,
    parameter int AWIDTH = 8
);
    logic              wr_en;
    logic              wr_sel;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              res_valid;
    logic              res_ready;
    logic [D_LEN-1:0]  res_data;
    logic [2:0]        res_err;
    logic [CTRL_W-1:0] ctrl;
    logic [LEN_W-1:0]  addr_rd;
    logic [DWIDTH-1:0] fin_a;
    logic [DWIDTH-1:0] fin_b;
    logic [7:0]        state;
    logic [D_LEN-1:0]  acc_out;
    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, cmd_valid, cmd_len, res_ready, addr_rd, state, acc_out,
        output cmd_ready, res_valid, res_data, res_err, ctrl, fin_a, fin_b
    );
    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, cmd_valid, cmd_len, res_ready, addr_rd, state, acc_out,
        input  cmd_ready, res_valid, res_data, res_err, ctrl, fin_a, fin_b
    );
endinterface

// File: rtl/mac_operand_ram.sv
// mac_operand_ram: single-write, registered-read operand store; out-of-range reads return zero
module mac_operand_ram #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int RWIDTH = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [RWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);
    logic [DWIDTH-1:0] r_mem [2**AWIDTH];
    logic              w_in_range;
    assign w_in_range = (i_raddr >> AWIDTH) == '0;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_rdata <= '0;
        else        o_rdata <= w_in_range ? r_mem[i_raddr[AWIDTH-1:0]] : '0;
    end
endmodule

// File: rtl/mac_host_sequencer.sv
// mac_host_sequencer: preloads operands, sequences one N_MAC command and returns its result or error
module mac_host_sequencer
    import mac_host_sequencer_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int D_LEN   = D_LEN_DEF,
    parameter int AWIDTH  = 8,
    parameter int TIMEOUT = 4096
) (
    input logic clk,
    input logic rst_n,
    mac_host_sequencer_if.slave bus
);
    localparam int DEPTH = 2**AWIDTH;
    localparam int TW    = $clog2(TIMEOUT);
    seq_state_e        r_state;
    logic              r_live;
    logic              r_fin_d;
    logic [LEN_W-1:0]  r_len;
    logic [TW-1:0]     r_cnt;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_res_valid;
    logic [D_LEN-1:0]  r_res_data;
    logic [2:0]        r_res_err;
    logic              w_idle;
    logic              w_len_bad;
    logic              w_mac_err;
    logic              w_fin_rise;
    logic              w_unused;
    // r_live keeps cmd_ready low while reset is asserted and for the release edge
    assign w_idle     = r_state == S_IDLE && r_live;
    assign w_len_bad  = bus.cmd_len == '0 || bus.cmd_len > LEN_W'(DEPTH);
    assign w_mac_err  = |bus.state[ST_REQUIRE_ERR:ST_BUS_CRASH];
    assign w_fin_rise = bus.state[ST_FINISH] & ~r_fin_d;
    assign w_unused   = ^{bus.state[7:ST_EDB_BUSY], bus.state[ST_MULT_BUSY:ST_ADDER_BUSY]};
    assign bus.cmd_ready = w_idle;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_err   = r_res_err;
    assign bus.ctrl      = r_ctrl;
    mac_operand_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .RWIDTH(LEN_W)) u_ram_a (
        .clk(clk), .rst_n(rst_n), .i_we(bus.wr_en & w_idle & ~bus.wr_sel),
        .i_waddr(bus.wr_addr), .i_wdata(bus.wr_data), .i_raddr(bus.addr_rd), .o_rdata(bus.fin_a)
    );
    mac_operand_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .RWIDTH(LEN_W)) u_ram_b (
        .clk(clk), .rst_n(rst_n), .i_we(bus.wr_en & w_idle & bus.wr_sel),
        .i_waddr(bus.wr_addr), .i_wdata(bus.wr_data), .i_raddr(bus.addr_rd), .o_rdata(bus.fin_b)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_fin_d     <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_ctrl      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= '0;
        end else begin
            r_live  <= 1'b1;
            r_fin_d <= bus.state[ST_FINISH];
            case (r_state)
                S_IDLE: if (w_idle && bus.cmd_valid) begin
                    if (w_len_bad) begin
                        r_res_valid <= 1'b1;
                        r_res_err   <= ERR_LEN;
                        r_res_data  <= '0;
                        r_state     <= S_RESULT;
                    end else begin
                        r_len   <= bus.cmd_len;
                        r_ctrl  <= mk_ctrl(1'b0, bus.cmd_len, 1'b1, 1'b0);
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_ctrl  <= mk_ctrl(1'b0, r_len, 1'b0, 1'b1);
                    r_state <= S_START;
                end
                S_START: begin
                    r_ctrl  <= mk_ctrl(1'b0, r_len, 1'b0, 1'b0);
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                // error flags outrank a finish seen in the same cycle
                S_WAIT: if (w_mac_err) begin
                    r_res_err <= ERR_MAC;
                    r_ctrl    <= mk_ctrl(1'b1, r_len, 1'b0, 1'b0);
                    r_state   <= S_ABORT;
                end else if (w_fin_rise) begin
                    r_ctrl  <= '0;
                    r_state <= S_CAPTURE;
                end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                    r_res_err <= ERR_TIMEOUT;
                    r_ctrl    <= mk_ctrl(1'b1, r_len, 1'b0, 1'b0);
                    r_state   <= S_ABORT;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    r_res_data  <= bus.acc_out;
                    r_res_err   <= '0;
                    r_res_valid <= 1'b1;
                    r_state     <= S_RESULT;
                end
                S_ABORT: begin
                    r_ctrl      <= '0;
                    r_res_data  <= '0;
                    r_res_valid <= 1'b1;
                    r_state     <= S_RESULT;
                end
                S_RESULT: if (bus.res_ready) begin
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
